// File: rtl/fta_bus_pkg.sv
// Shared FTA bus types: transaction id, request/response beats, request queue entry and queue FSM states.
package fta_bus_pkg;

    localparam int FTA_WID = 256;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [7:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic                   cyc;
        logic                   we;
        logic [4:0]             cmd;
        fta_tranid_t            tid;
        logic [5:0]             blen;
        logic [FTA_WID/8-1:0]   sel;
        logic [31:0]            adr;
        logic [FTA_WID-1:0]     data1;
    } fta_cmd_request_t;

    typedef struct packed {
        logic                   ack;
        logic                   rty;
        logic                   stall;
        fta_tranid_t            tid;
        logic [31:0]            adr;
        logic [FTA_WID-1:0]     dat;
    } fta_cmd_response_t;

    typedef struct packed {
        fta_tranid_t            tid;
        logic                   we;
        logic [5:0]             blen;
        logic [FTA_WID/8-1:0]   sel;
        logic [31:0]            adr;
        logic [FTA_WID-1:0]     data1;
    } fta_req_entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} fta_req_state_t;

endpackage

// File: rtl/fta_bus_interface.sv
// FTA bus bundle: a request struct driven by the master and a response struct driven by the slave.
interface fta_bus_interface;
    import fta_bus_pkg::*;

    fta_cmd_request_t  req;
    fta_cmd_response_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/fta_req_fifo.sv
// Request FIFO with wrapping pointers; full/empty come from an occupancy counter one bit wider than the pointers.
module fta_req_fifo
    import fta_bus_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fta_req_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) store[wr_ptr] <= din;
    end
endmodule

// File: rtl/fta_req_queue.sv
// Queues FTA requests and replays them (including bursts) onto a simple req/ack memory port.
// FTA_REQ_QUEUE_RTY_EN: answer requests dropped on a full queue with resp.rty instead of the sticky ovf_o flag.
module fta_req_queue
    import fta_bus_pkg::*;
#(
    parameter int         WID    = 256,
    parameter int         DEPTH  = 4,
    parameter logic [5:0] CORENO = 6'd1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fta_bus_interface.slave   fta_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [WID/8-1:0]  mem_sel_o,
    output logic [31:0]       mem_adr_o,
    output logic [WID-1:0]    mem_dat_o,
    input  logic              mem_ack_i,
    input  logic [WID-1:0]    mem_dat_i,
    output logic              ovf_o
);
    localparam int          CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] STEP  = 32'(WID/8);

    fta_req_state_t     state;
    fta_req_entry_t     push_entry;
    fta_req_entry_t     fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   occ;
    logic               push;
    logic               pop;
    logic               drop;
    logic               ack_set;
    logic               cont_beat;
    logic [5:0]         beat_cnt;
    fta_tranid_t        cur_tid;
    logic               resp_ack;
    logic               resp_rty;
    fta_tranid_t        resp_tid;
    logic [31:0]        resp_adr;
    logic [FTA_WID-1:0] resp_dat;
    logic [15:0]        own_req_cnt;
    logic               unused_dbg;

    assign push       = fta_i.req.cyc && !fifo_full;
    assign drop       = fta_i.req.cyc && fifo_full;
    assign pop        = (state == ISSUE) && !cont_beat;
    assign ack_set    = (state == WAIT_ACK) && mem_ack_i;
    assign unused_dbg = ^{own_req_cnt, fta_i.req.cmd};

    assign push_entry = '{tid: fta_i.req.tid, we: fta_i.req.we, blen: fta_i.req.blen,
                          sel: fta_i.req.sel, adr: fta_i.req.adr, data1: fta_i.req.data1};

    assign fta_i.resp = '{ack: resp_ack, rty: resp_rty, stall: (occ >= CNT_W'(DEPTH-1)),
                          tid: resp_tid, adr: resp_adr, dat: resp_dat};

    fta_req_fifo #(.DEPTH(DEPTH), .entry_t(fta_req_entry_t)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (occ)
    );

`ifdef FTA_REQ_QUEUE_RTY_EN
    logic        rty_pend;
    fta_tranid_t rty_tid;
    assign ovf_o = 1'b0;
`else
    logic        ovf_q;
    assign ovf_o = ovf_q;
`endif

    // Burst beats after the first reuse the held mem_* registers: step the address, open all lanes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cont_beat   <= 1'b0;
            beat_cnt    <= '0;
            cur_tid     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_sel_o   <= '0;
            mem_adr_o   <= '0;
            mem_dat_o   <= '0;
            resp_ack    <= 1'b0;
            resp_rty    <= 1'b0;
            resp_tid    <= '0;
            resp_adr    <= '0;
            resp_dat    <= '0;
            own_req_cnt <= '0;
`ifdef FTA_REQ_QUEUE_RTY_EN
            rty_pend    <= 1'b0;
            rty_tid     <= '0;
`else
            ovf_q       <= 1'b0;
`endif
        end else begin
            resp_ack <= 1'b0;
            resp_rty <= 1'b0;
            if (push && (fta_i.req.tid.core == CORENO))
                own_req_cnt <= own_req_cnt + 16'd1;

            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cont_beat <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req_o <= 1'b1;
                    if (cont_beat) begin
                        mem_adr_o <= mem_adr_o + STEP;
                        mem_sel_o <= '1;
                        beat_cnt  <= beat_cnt - 6'd1;
                    end else begin
                        mem_we_o  <= fifo_dout.we;
                        mem_sel_o <= fifo_dout.sel[WID/8-1:0];
                        mem_adr_o <= fifo_dout.adr;
                        mem_dat_o <= fifo_dout.data1[WID-1:0];
                        beat_cnt  <= fifo_dout.blen;
                        cur_tid   <= fifo_dout.tid;
                    end
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        resp_ack  <= 1'b1;
                        resp_tid  <= cur_tid;
                        resp_adr  <= mem_adr_o;
                        resp_dat  <= mem_we_o ? '0 : FTA_WID'(mem_dat_i);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    cont_beat <= (beat_cnt != 6'd0);
                    state     <= (beat_cnt != 6'd0) ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef FTA_REQ_QUEUE_RTY_EN
            // A retry colliding with an ack waits one deep in rty_pend so ack and rty never coincide.
            if (!ack_set && (drop || rty_pend)) begin
                resp_rty <= 1'b1;
                resp_tid <= rty_pend ? rty_tid : fta_i.req.tid;
            end
            rty_pend <= ack_set ? (rty_pend || drop) : (rty_pend && drop);
            if (drop && !(ack_set && rty_pend))
                rty_tid <= fta_i.req.tid;
`else
            if (drop) ovf_q <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_fta_req_queue.sv
// Directed self-checking bench for fta_req_queue: singles, bursts, address wrap, overflow, push/pop overlap, reset.
module tb_fta_req_queue;

    logic         clk_i     = 1'b0;
    logic         rst_ni    = 1'b0;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_sel_o;
    logic [31:0]  mem_adr_o;
    logic [255:0] mem_dat_o;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_dat_i = '0;
    logic         ovf_o;

    int errors = 0;
    int checks = 0;

    bit ack_en    = 1'b0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    int overlap   = 0;

    logic [16:0]  ack_tid [$];
    logic [31:0]  ack_adr [$];
    logic [255:0] ack_dat [$];
    logic [31:0]  beat_sel [$];
    logic [255:0] beat_wdat [$];

    fta_bus_interface fta_if();

    fta_req_queue #(.WID(256), .DEPTH(4), .CORENO(6'd1)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .fta_i    (fta_if),
        .mem_req_o(mem_req_o),
        .mem_we_o (mem_we_o),
        .mem_sel_o(mem_sel_o),
        .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o),
        .mem_ack_i(mem_ack_i),
        .mem_dat_i(mem_dat_i),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] rd_model(input logic [31:0] adr);
        return {8{adr ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [255:0] data_pat(input int i);
        return {8{32'hD00D_0000 + 32'(i)}};
    endfunction

    function automatic logic [16:0] mk_tid(input logic [5:0] c, input logic [2:0] ch, input logic [7:0] t);
        return {c, ch, t};
    endfunction

    // Memory model: acks mem_req_o after ack_delay extra cycles, returning an address-derived pattern.
    always @(posedge clk_i) begin
        #2;
        if (!rst_ni || !mem_req_o || mem_ack_i || !ack_en) begin
            mem_ack_i = 1'b0;
            if (!mem_req_o) wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack_i = 1'b1;
            mem_dat_i = rd_model(mem_adr_o);
            beat_sel.push_back(mem_sel_o);
            beat_wdat.push_back(mem_dat_o);
            wait_cnt = 0;
        end else begin
            wait_cnt++;
        end
    end

    // Response monitor.
    always @(negedge clk_i) begin
        if (fta_if.resp.ack) begin
            ack_tid.push_back(fta_if.resp.tid);
            ack_adr.push_back(fta_if.resp.adr);
            ack_dat.push_back(fta_if.resp.dat);
        end
        if (fta_if.resp.ack && fta_if.resp.rty) overlap++;
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [16:0] tid, input logic [5:0] blen,
                                 input logic [31:0] sel, input logic [31:0] adr, input logic [255:0] data);
        fta_if.req.cyc   = 1'b1;
        fta_if.req.we    = we;
        fta_if.req.cmd   = we ? 5'd2 : 5'd1;
        fta_if.req.tid   = tid;
        fta_if.req.blen  = blen;
        fta_if.req.sel   = sel;
        fta_if.req.adr   = adr;
        fta_if.req.data1 = data;
        @(negedge clk_i);
        fta_if.req.cyc   = 1'b0;
    endtask

    task automatic waitAcks(input string tag, input int target, input int budget);
        int n = 0;
        while (ack_tid.size() < target && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput(tag, 256'(ack_tid.size()), 256'(target));
    endtask

    task automatic waitMemReq(input string tag, input int budget);
        int n = 0;
        while (!mem_req_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput(tag, 256'(mem_req_o), 256'(1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int bbase;
        int n;
        fta_if.req = '0;

        // Reset state
        repeat (3) @(negedge clk_i);
        checkOutput("rst_mem_req", 256'(mem_req_o), 256'(0));
        checkOutput("rst_mem_adr", 256'(mem_adr_o), 256'(0));
        checkOutput("rst_resp_ack", 256'(fta_if.resp.ack), 256'(0));
        checkOutput("rst_stall", 256'(fta_if.resp.stall), 256'(0));
        checkOutput("rst_ovf", 256'(ovf_o), 256'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single load, mem ack two cycles after request
        ack_en = 1'b1;
        ack_delay = 1;
        base = ack_tid.size();
        applyStimulus(1'b0, mk_tid(6'd1, 3'd0, 8'd1), 6'd0, '1, 32'h0000_0100, '0);
        waitAcks("t1_count", base + 1, 40);
        checkOutput("t1_tid", 256'(ack_tid[base]), 256'(mk_tid(6'd1, 3'd0, 8'd1)));
        checkOutput("t1_adr", 256'(ack_adr[base]), 256'(32'h100));
        checkOutput("t1_dat", ack_dat[base], rd_model(32'h100));

        // Load burst of four beats
        base = ack_tid.size();
        bbase = beat_sel.size();
        applyStimulus(1'b0, mk_tid(6'd1, 3'd1, 8'd2), 6'd3, 32'h0000_00FF, 32'h0000_0200, '0);
        waitAcks("t2_count", base + 4, 80);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_adr%0d", i), 256'(ack_adr[base+i]), 256'(32'h200 + 32'h20 * i));
            checkOutput($sformatf("t2_tid%0d", i), 256'(ack_tid[base+i]), 256'(mk_tid(6'd1, 3'd1, 8'd2)));
            checkOutput($sformatf("t2_dat%0d", i), ack_dat[base+i], rd_model(32'h200 + 32'h20 * i));
        end
        checkOutput("t2_sel0", 256'(beat_sel[bbase]), 256'(32'h0000_00FF));
        checkOutput("t2_sel1", 256'(beat_sel[bbase+1]), 256'(32'hFFFF_FFFF));

        // Burst address wraps past 2^32
        base = ack_tid.size();
        applyStimulus(1'b0, mk_tid(6'd2, 3'd0, 8'd3), 6'd1, '1, 32'hFFFF_FFE0, '0);
        waitAcks("t3_count", base + 2, 60);
        checkOutput("t3_adr0", 256'(ack_adr[base]), 256'(32'hFFFF_FFE0));
        checkOutput("t3_adr1", 256'(ack_adr[base+1]), 256'(32'h0000_0000));

        // Stores pile up behind a stalled access; the fifth is dropped
        ack_en = 1'b0;
        base = ack_tid.size();
        bbase = beat_wdat.size();
        applyStimulus(1'b1, mk_tid(6'd1, 3'd2, 8'h10), 6'd0, '1, 32'h0000_1000, data_pat(0));
        waitMemReq("t4_s0_issue", 20);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, mk_tid(6'd1, 3'd2, 8'(8'h10 + i)), 6'd0, '1, 32'h1000 + 32'(32 * i), data_pat(i));
            checkOutput($sformatf("t4_stall%0d", i), 256'(fta_if.resp.stall), 256'(i >= 3));
        end
`ifdef FTA_REQ_QUEUE_RTY_EN
        checkOutput("t4_rty", 256'(fta_if.resp.rty), 256'(1));
        checkOutput("t4_rty_tid", 256'(fta_if.resp.tid), 256'(mk_tid(6'd1, 3'd2, 8'h15)));
        checkOutput("t4_ovf", 256'(ovf_o), 256'(0));
`else
        checkOutput("t4_ovf", 256'(ovf_o), 256'(1));
        checkOutput("t4_rty", 256'(fta_if.resp.rty), 256'(0));
`endif
        ack_delay = 0;
        ack_en = 1'b1;
        waitAcks("t4_count", base + 5, 100);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t4_tid%0d", k), 256'(ack_tid[base+k]), 256'(mk_tid(6'd1, 3'd2, 8'(8'h10 + k))));
            checkOutput($sformatf("t4_dat%0d", k), ack_dat[base+k], '0);
            checkOutput($sformatf("t4_wdat%0d", k), beat_wdat[bbase+k], data_pat(k));
        end
        checkOutput("t4_stall_drained", 256'(fta_if.resp.stall), 256'(0));

        // Push on the ISSUE pop cycle at occupancy 2
        ack_en = 1'b0;
        base = ack_tid.size();
        applyStimulus(1'b0, mk_tid(6'd3, 3'd0, 8'h30), 6'd0, '1, 32'h0000_3000, '0);
        waitMemReq("t5_a_issue", 20);
        applyStimulus(1'b0, mk_tid(6'd3, 3'd0, 8'h31), 6'd0, '1, 32'h0000_3100, '0);
        applyStimulus(1'b0, mk_tid(6'd3, 3'd0, 8'h32), 6'd0, '1, 32'h0000_3200, '0);
        checkOutput("t5_stall_occ2", 256'(fta_if.resp.stall), 256'(0));
        ack_en = 1'b1;
        n = 0;
        while (!fta_if.resp.ack && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("t5_a_ack", 256'(fta_if.resp.ack), 256'(1));
        ack_en = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        applyStimulus(1'b0, mk_tid(6'd3, 3'd0, 8'h33), 6'd0, '1, 32'h0000_3300, '0);
        checkOutput("t5_b_issued", 256'(mem_req_o), 256'(1));
        checkOutput("t5_stall_same", 256'(fta_if.resp.stall), 256'(0));
        applyStimulus(1'b0, mk_tid(6'd3, 3'd0, 8'h34), 6'd0, '1, 32'h0000_3400, '0);
        checkOutput("t5_stall_occ3", 256'(fta_if.resp.stall), 256'(1));
        ack_en = 1'b1;
        waitAcks("t5_count", base + 5, 100);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("t5_tid%0d", k), 256'(ack_tid[base+k]), 256'(mk_tid(6'd3, 3'd0, 8'(8'h30 + k))));

        // Reset while a burst waits for its first ack, with another request queued
        ack_en = 1'b0;
        applyStimulus(1'b0, mk_tid(6'd4, 3'd0, 8'h40), 6'd3, '1, 32'h0000_4000, '0);
        applyStimulus(1'b1, mk_tid(6'd4, 3'd0, 8'h41), 6'd0, '1, 32'h0000_4100, data_pat(9));
        waitMemReq("t6_issue", 20);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_mem_req", 256'(mem_req_o), 256'(0));
        checkOutput("t6_mem_adr", 256'(mem_adr_o), 256'(0));
        checkOutput("t6_mem_sel", 256'(mem_sel_o), 256'(0));
        checkOutput("t6_mem_we", 256'(mem_we_o), 256'(0));
        checkOutput("t6_mem_dat", mem_dat_o, '0);
        checkOutput("t6_ovf", 256'(ovf_o), 256'(0));
        @(negedge clk_i);
        checkOutput("t6_resp_ack", 256'(fta_if.resp.ack), 256'(0));
        checkOutput("t6_resp_tid", 256'(fta_if.resp.tid), 256'(0));
        checkOutput("t6_resp_stall", 256'(fta_if.resp.stall), 256'(0));
        rst_ni = 1'b1;
        ack_en = 1'b1;
        base = ack_tid.size();
        repeat (20) @(negedge clk_i);
        checkOutput("t6_no_acks", 256'(ack_tid.size()), 256'(base));
        checkOutput("t6_idle_req", 256'(mem_req_o), 256'(0));

        checkOutput("ack_rty_overlap", 256'(overlap), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fta_req_queue.md
FTA_REQ_QUEUE -- requirements
Module: fta_req_queue

Interface
REQ-001 SHALL have parameter WID, default 256, data width in bits (WID/8 byte lanes).
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CORENO, default 6'd1, core number checked in tid for debug counting only.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fta_i, fta_bus_interface.slave; .req is the input request (cyc, we, cmd, tid, blen, sel, adr, data1) and .resp is the output response (ack, rty, stall, tid, adr, dat).
REQ-007 SHALL have port mem_req_o, output, 1, memory access strobe, held until mem_ack_i.
REQ-008 SHALL have port mem_we_o, output, 1, memory write enable.
REQ-009 SHALL have port mem_sel_o, output, WID/8, byte enables.
REQ-010 SHALL have port mem_adr_o, output, 32, byte address.
REQ-011 SHALL have port mem_dat_o, output, WID, write data.
REQ-012 SHALL have port mem_ack_i, input, 1, one-cycle memory completion.
REQ-013 SHALL have port mem_dat_i, input, WID, read data, valid with mem_ack_i.
REQ-014 SHALL have port ovf_o, output, 1, sticky request-dropped flag.

Function
REQ-015 SHALL capture fta_i.req (tid, we, blen, sel, adr, data1) into the FIFO on any cycle with req.cyc=1 and FIFO not full; single-cycle req pulses are accepted.
REQ-016 SHALL drive resp.stall=1 combinationally while occupancy >= DEPTH-1.
REQ-017 SHALL use a control FSM: IDLE, ISSUE, WAIT_ACK, RESP.
REQ-018 IDLE -> ISSUE when FIFO non-empty; ISSUE pops the head, loads beat counter = blen, and asserts mem_req_o; -> WAIT_ACK.
REQ-019 WAIT_ACK holds mem_* stable until mem_ack_i, latches mem_dat_i, -> RESP.
REQ-020 RESP drives resp.ack=1 for exactly one cycle with stored tid, beat address, and latched data (stores: dat=0); then -> ISSUE-next-beat if beat counter != 0, else IDLE.
REQ-021 Burst beats SHALL increment the address by WID/8 modulo 2^32 and decrement the counter; sel forced all-ones for beats after the first.
REQ-022 Store bursts SHALL write data1 on every beat (no per-beat data).
REQ-023 Minimum single-access latency: capture cycle + 1 (ISSUE) + mem latency + 1 (RESP).
REQ-024 Simultaneous push and pop SHALL be permitted; occupancy unchanged.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full/empty from an occupancy counter of width clog2(DEPTH)+1.
REQ-026 resp.rty, resp.ack SHALL never both be 1 in one cycle.

Reset
REQ-027 On rst_ni=0: FSM=IDLE, FIFO empty, mem_req_o=0, mem_we_o=0, mem_sel_o=0, mem_adr_o=0, mem_dat_o=0, resp fields all 0, ovf_o=0.
REQ-028 Reset mid-burst SHALL abandon the burst and drop all queued requests; no response is issued.

Configuration
REQ-029 With FTA_REQ_QUEUE_RTY_EN defined: req.cyc arriving when full SHALL be dropped and answered next cycle with resp.rty=1 and its tid; ovf_o unaffected.
REQ-030 Without FTA_REQ_QUEUE_RTY_EN: such a request SHALL be dropped silently and ovf_o set to 1 until reset; resp.rty constant 0.

Structure
REQ-031 FSM state enum and the per-entry request struct SHALL live in fta_bus_pkg; no new package.
REQ-032 The FIFO SHALL be a sub-module fta_req_fifo (DEPTH, entry type), instanced once.

Verification
REQ-033 Single load adr=0x100, tid={1,0,1}, mem_ack 2 cycles after req -> one resp.ack with adr=0x100, tid echoed, dat=mem_dat_i.
REQ-034 Load burst blen=3 adr=0x200, WID=256 -> four acks, adr 0x200,0x220,0x240,0x260.
REQ-035 Five back-to-back stores with mem_ack held low -> stall rises after 3rd capture; 5th dropped; rty pulse if FTA_REQ_QUEUE_RTY_EN else ovf_o=1.
REQ-036 Burst adr=0xFFFFFFE0 blen=1 -> second beat adr=0x00000000.
REQ-037 rst_ni low during WAIT_ACK of a burst -> all outputs 0 next cycle, no further acks after release.
REQ-038 Push on same cycle as ISSUE pop at occupancy 2 -> occupancy stays 2, order preserved.
